// File: rtl/adder_tree_sched_pkg.sv
// Shared types, widths and helpers for the adder-tree scheduler.
package adder_tree_sched_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_WIDTH        = 16;
    localparam int DEF_NUM_OPS      = 5;
    localparam int DEF_TREE_LATENCY = 3;

    // Tag ids are sized for the largest supported requester count so one
    // tag type serves every configuration; the top narrows on the way out.
    localparam int NUM_REQ_MAX = 8;
    localparam int ID_W        = $clog2(NUM_REQ_MAX);
    localparam int CNT_W       = $clog2(DEF_TREE_LATENCY + 3);

    // Upper bound on NUM_OPS*WIDTH accepted by zero_upper_ops.
    localparam int OPS_BUS_MAX = 1024;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // In 3-operand mode everything above operand 2 is cleared, so the
    // tree adds zeros in the unused lanes.
    function automatic logic [OPS_BUS_MAX-1:0] zero_upper_ops(
        input logic [OPS_BUS_MAX-1:0] ops,
        input int                     width,
        input logic                   mode3
    );
        logic [OPS_BUS_MAX-1:0] r;
        r = ops;
        if (mode3) begin
            for (int b = 0; b < OPS_BUS_MAX; b++) begin
                if (b >= 3 * width) r[b] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_tree_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module adder_tree_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_next;
    int               cand;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (enable && !grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        if (grant_idx == IDX_W'(NUM_REQ - 1)) ptr_next = '0;
        else                                   ptr_next = grant_idx + 1'b1;
    end

    // Pointer register; holds when nothing is granted or the scheduler is stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          ptr_q <= '0;
        else if (grant_any) ptr_q <= ptr_next;
    end

endmodule

// File: rtl/adder_tree_scheduler.sv
// Shares one pipelined adder tree among NUM_REQ requesters and returns each
// sum tagged with the id of the requester that issued it.
module adder_tree_scheduler
    import adder_tree_sched_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int WIDTH        = DEF_WIDTH,
    parameter int NUM_OPS      = DEF_NUM_OPS,
    parameter int TREE_LATENCY = DEF_TREE_LATENCY
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic [NUM_REQ-1:0]                i_req_valid,
    output logic [NUM_REQ-1:0]                o_req_ready,
    input  logic [NUM_REQ*NUM_OPS*WIDTH-1:0]  i_req_data,
    input  logic [NUM_REQ-1:0]                i_req_mode3,
    input  logic                              i_stall,
    output logic                              o_tree_enable,
    output logic                              o_tree_valid,
    output logic [NUM_OPS*WIDTH-1:0]          o_tree_data,
    input  logic [WIDTH-1:0]                  i_tree_result,
    output logic                              o_res_valid,
    output logic [$clog2(NUM_REQ)-1:0]        o_res_id,
    output logic [WIDTH-1:0]                  o_res_data,
    output logic [$clog2(TREE_LATENCY+3)-1:0] o_inflight
);

    localparam int RID_W = $clog2(NUM_REQ);
    localparam int INF_W = $clog2(TREE_LATENCY + 3);
    localparam int BUS_W = NUM_OPS * WIDTH;

    logic [NUM_REQ-1:0] grant;
    logic [RID_W-1:0]   grant_idx;
    logic               grant_any;

    logic [BUS_W-1:0]   sel_ops;
    logic [BUS_W-1:0]   masked_ops;

    logic               tree_valid_q;
    logic [BUS_W-1:0]   tree_data_q;
    logic [RID_W-1:0]   tree_id_q;

    tag_t               tag_in;
    tag_t               tag_q [TREE_LATENCY];

    logic               res_valid_q;
    logic [RID_W-1:0]   res_id_q;
    logic [WIDTH-1:0]   res_data_q;
    logic [INF_W-1:0]   inflight_q;

    assign o_tree_enable = ~i_stall;

    adder_tree_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clock     (i_clock),
        .reset     (i_reset),
        .req_valid (i_req_valid),
        .enable    (o_tree_enable),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign o_req_ready = grant;

    assign sel_ops    = i_req_data[int'(grant_idx)*BUS_W +: BUS_W];
    assign masked_ops = BUS_W'(zero_upper_ops(OPS_BUS_MAX'(sel_ops), WIDTH,
                                              i_req_mode3[grant_idx]));

    // Issue stage: registers the winner's operands for the tree; frozen by stall.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tree_valid_q <= 1'b0;
            tree_data_q  <= '0;
            tree_id_q    <= '0;
        end else if (!i_stall) begin
            tree_valid_q <= grant_any;
            if (grant_any) begin
                tree_data_q <= masked_ops;
                tree_id_q   <= grant_idx;
            end
        end
    end

    assign tag_in.valid = tree_valid_q;
    assign tag_in.id    = ID_W'(tree_id_q);

    // Tag pipeline shadows the tree stages, advancing only when the tree does.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < TREE_LATENCY; i++) tag_q[i] <= '0;
        end else if (!i_stall) begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < TREE_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Result capture; the strobe drops during stall so a held result never re-pulses.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else if (i_stall) begin
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= tag_q[TREE_LATENCY-1].valid;
            if (tag_q[TREE_LATENCY-1].valid) begin
                res_id_q   <= RID_W'(tag_q[TREE_LATENCY-1].id);
                res_data_q <= i_tree_result;
            end
        end
    end

    // Outstanding-request counter: up on accept, down on result strobe.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            inflight_q <= '0;
        end else begin
            unique case ({grant_any, res_valid_q})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign o_tree_valid = tree_valid_q;
    assign o_tree_data  = tree_data_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_id     = res_id_q;
    assign o_res_data   = res_data_q;
    assign o_inflight   = inflight_q;

endmodule
